// File: rtl/serial_sub_pkg.sv
// Shared types for the serial subtractor: FSM state encoding and counter sizing.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // A one-slice configuration still needs a one-bit counter.
   function automatic int cnt_width(input int slices);
      return (slices > 1) ? $clog2(slices) : 1;
   endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational CHUNK-bit subtractor with borrow-in and borrow-out.
module sub_slice #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             bin,
   output logic [CHUNK-1:0] d,
   output logic             bout
);

   logic [CHUNK:0] full;

   // One extra bit catches the borrow as the sign of the widened difference.
   always_comb begin
      full = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
   end

   assign d    = full[CHUNK-1:0];
   assign bout = full[CHUNK];

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Multi-cycle N-bit subtractor, one CHUNK-bit slice per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module serial_subtractor_nbit
   import serial_sub_pkg::*;
#(
   parameter int N     = 32,
   parameter int CHUNK = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] diff,
   output logic         bout
`ifdef SUB_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int SLICES = N / CHUNK;
   localparam int CNT_W  = cnt_width(SLICES);

   generate
      if ((N % CHUNK) != 0) begin : g_bad_chunk
         $error("serial_subtractor_nbit: N must be a multiple of CHUNK");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [N-1:0]     diff_q, diff_d;
   logic             bout_q, bout_d;
   logic [N-1:0]     x_q, x_d;
   logic [N-1:0]     y_q, y_d;
   logic [N-1:0]     part_q, part_d;
`ifdef SUB_OVF_EN
   logic             ovf_q, ovf_d;
   logic             xs_q, xs_d;
   logic             ys_q, ys_d;
`endif

   logic [CHUNK-1:0] a_s, b_s, d_s;
   logic             bo_s;

   // Single slice datapath, operands selected by the slice counter.
   assign a_s = x_q[int'(cnt_q)*CHUNK +: CHUNK];
   assign b_s = y_q[int'(cnt_q)*CHUNK +: CHUNK];

   sub_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (a_s),
      .b    (b_s),
      .bin  (borrow_q),
      .d    (d_s),
      .bout (bo_s)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      borrow_d    = borrow_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      diff_d      = diff_q;
      bout_d      = bout_q;
      x_d         = x_q;
      y_d         = y_q;
      part_d      = part_q;
`ifdef SUB_OVF_EN
      ovf_d       = ovf_q;
      xs_d        = xs_q;
      ys_d        = ys_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               x_d        = x;
               y_d        = y;
               cnt_d      = '0;
               borrow_d   = 1'b0;
               in_ready_d = 1'b0;
               state_d    = RUN;
`ifdef SUB_OVF_EN
               xs_d       = x[N-1];
               ys_d       = y[N-1];
`endif
            end
         end
         RUN: begin
            part_d[int'(cnt_q)*CHUNK +: CHUNK] = d_s;
            borrow_d = bo_s;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SLICES - 1)) begin
               diff_d      = part_d;
               bout_d      = bo_s;
               out_valid_d = 1'b1;
               state_d     = DONE;
`ifdef SUB_OVF_EN
               ovf_d       = (xs_q != ys_q) && (part_d[N-1] != xs_q);
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         borrow_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         bout_q      <= 1'b0;
`ifdef SUB_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         borrow_q    <= borrow_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         diff_q      <= diff_d;
         bout_q      <= bout_d;
`ifdef SUB_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   // Operand and partial-result storage is only meaningful inside an operation.
   always_ff @(posedge clk) begin
      x_q    <= x_d;
      y_q    <= y_d;
      part_q <= part_d;
`ifdef SUB_OVF_EN
      xs_q   <= xs_d;
      ys_q   <= ys_d;
`endif
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign bout      = bout_q;
`ifdef SUB_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule
